// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO-to-stream reader slice.
package tpu_stream_pkg;

    // Reader control states: waiting for a command, issuing reads, emptying the buffer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Output buffer depth; covers the one-cycle FIFO read latency plus a stalled word.
    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Command, FIFO-side and stream-side signals of the reader, bundled for port use.
interface fifo_stream_reader_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_r_en;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    // Reader side.
    modport master (
        input  start, len, fifo_rdata, fifo_empty, m_ready,
        output busy, done, fifo_r_en, m_valid, m_data, m_last
    );

    // Commander / FIFO / sink side.
    modport slave (
        output start, len, fifo_rdata, fifo_empty, m_ready,
        input  busy, done, fifo_r_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry circular buffer with push/pop, exposing occupancy and the head word.
module stream_skid_buf
    import tpu_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    // Next-state: write at the tail on push, advance the head on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    // Buffer registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Burst reader: pulls a commanded number of words from a FIFO and presents them
// as a valid/ready stream with last on the final word.
module fifo_stream_reader
    import tpu_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 8
) (
    input logic                 clk,
    input logic                 rstn,
    fifo_stream_reader_if.master bus
);
    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] popped_q, popped_d;
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;

    logic [1:0]       occ;
    logic [WIDTH-1:0] head;
    logic             m_valid;
    logic             pop;
    logic             r_en;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & bus.m_ready;

    // Read issue: a pop in the same cycle frees the slot the new word will land in.
    always_comb begin
        r_en = (state_q == RUN) && !bus.fifo_empty && (issued_q != len_q) &&
               ((({1'b0, occ} + {2'b00, inflight_q}) < 3'(BUF_DEPTH)) || pop);
    end

    // Next-state for the burst FSM, counters and done pulse.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        inflight_d = r_en;
        done_d     = 1'b0;
        if (pop) begin
            popped_d = popped_q + LEN_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        len_d    = bus.len;
                        issued_d = '0;
                        popped_d = '0;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (r_en) begin
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (popped_q == len_q - LEN_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data (bus.fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign bus.fifo_r_en = r_en;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = head;
    assign bus.m_last    = m_valid && (popped_q == len_q - LEN_W'(1));

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side engine for the team's synchronous FIFO. Drives the FIFO read enable, captures the registered read data, and presents words as a valid/ready stream to the systolic-array feeder.
- Runs bursts of a commanded length and marks the final word with last. Sustains one word per cycle when the FIFO is non-empty and the sink is ready.
- Sits between each weight/activation FIFO and the PE-row input skew logic.

Parameters:
- WIDTH, 16, data word width; must match the FIFO WIDTH.
- LEN_W, 8, burst length counter width; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  burst command strobe, sampled in IDLE only
- len  in  LEN_W  burst length, sampled with start
- busy  out  1  high while a burst is active (state != IDLE)
- done  out  1  one-cycle pulse after the final stream handshake
- fifo_r_en  out  1  FIFO read enable
- fifo_rdata  in  WIDTH  FIFO data_out; valid the cycle after an accepted r_en
- fifo_empty  in  1  FIFO empty flag
- m_valid  out  1  output stream valid
- m_data  out  WIDTH  output stream data
- m_last  out  1  high with the final word of a burst
- m_ready  in  1  output stream ready

Behaviour:
- Interface: one clock, clk; reset rstn is synchronous and active-low. All state changes occur on posedge clk.
- Reset: while rstn is low at a posedge, state=IDLE and counters/buffer/inflight are cleared.
  - Outputs in reset: busy=0, done=0, fifo_r_en=0, m_valid=0, m_data=0, m_last=0.
  - Reset mid-burst discards all buffered and in-flight words. No done pulse is generated.
- FSM:
  - IDLE: start=1 with len!=0 latches len, clears issued/popped counters, goes to RUN. start=1 with len==0 stays in IDLE and pulses done in the next cycle.
  - RUN: issues reads. Moves to DRAIN when issued==len after an accepted read.
  - DRAIN: no reads. Returns to IDLE on the handshake (m_valid&m_ready) of the word where popped==len-1.
  - start is ignored while busy.
- Read issue (combinational): fifo_r_en = (state==RUN) & !fifo_empty & (issued!=len) & (occ+inflight<2 | pop).
  - occ = buffer occupancy, 0..2; inflight = read issued last cycle; pop = m_valid & m_ready.
  - fifo_r_en is never asserted while fifo_empty=1.
- Capture:
  - inflight <= fifo_r_en. When inflight=1, fifo_rdata is written into the 2-entry buffer at that posedge.
  - Latency: r_en in cycle t -> word visible on m_data in cycle t+2 if the buffer was empty.
- Stream rules:
  - m_valid = occ!=0. m_data = head entry.
  - Once m_valid is high, m_data and m_last stay stable until the handshake.
  - A simultaneous push and pop keeps occ unchanged. The buffer never overflows; this is guaranteed by the issue rule.
- m_last = m_valid & (popped==len-1).
- done: registered; high exactly one cycle, the cycle after the last handshake. busy is 0 in that cycle.
- Counter arithmetic: issued and popped are LEN_W bits unsigned with no wrap. Both are bounded by the latched len.
- Throughput: with fifo_empty=0 and m_ready=1 held, one handshake per cycle from cycle t+2 onward.
- Backpressure: m_ready=0 stops reads after at most 2 words are held (occ+inflight≤2).

Decomposition:
- Package tpu_stream_pkg: rd_state_e enum {IDLE, RUN, DRAIN}, plus the constant BUF_DEPTH=2.
- Sub-module stream_skid_buf (WIDTH): 2-entry buffer with push/pop, occ output, head data. It is reusable by other stream endpoints.
- The FSM, counters, and issue logic live in fifo_stream_reader.

Test Plan:
- Basic burst: FIFO preloaded with 0x0001..0x0004, start with len=4, m_ready=1.
  - r_en high for 4 consecutive cycles starting the cycle after start.
  - m_data 0x0001..0x0004 on consecutive cycles; m_last with 0x0004.
  - done pulses once, the cycle after.
- Backpressure: len=6, m_ready=0 for 5 cycles, then 1.
  - Exactly 2 reads issued during the stall; m_data holds 0x0001 stable.
  - All 6 words are delivered in order with no loss or duplicate.
- Underflow: FIFO empty at start, len=3; words pushed into the FIFO at cycles 4, 9, 10.
  - r_en never asserted while empty.
  - Three words delivered in order; m_last on the third.
- Zero length: start with len=0 -> busy stays 0, done pulses the next cycle, no r_en, no m_valid.
- Reset mid-burst: len=8, rstn=0 after 3 handshakes.
  - The next cycle shows busy=0, m_valid=0, fifo_r_en=0, and no done.
  - A new start with len=2 then completes normally.
- Start while busy: a second start with len=5 during a len=4 burst is ignored. Exactly 4 words and one done are produced.
